// File: rtl/ram_access_ctrl.sv
// Req/ack access controller for a small bank of RAM words: latches one request, drives the one-hot
// select and write strobe, and captures read data. Optional write-verify: define VERIFY_EN.
module ram_access_ctrl #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                           clk_i,
    input  logic                           clear_i,
    input  logic                           req_i,
    input  logic                           rw_i,
    input  logic [ADDR_W-1:0]              addr_i,
    input  logic [DATA_W-1:0]              wdata_i,
    output logic                           ack_o,
    output logic                           busy_o,
    output logic [DATA_W-1:0]              rdata_o,
    output logic                           err_o,
    output logic [(2**ADDR_W)-1:0]         ram_sel_o,
    output logic                           ram_we_o,
    output logic [DATA_W-1:0]              ram_din_o,
    output logic                           ram_clr_o,
    input  logic [DATA_W*(2**ADDR_W)-1:0]  ram_dout_i
);

    localparam int unsigned WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StCapture,
        StDone,
        StVerify
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rw_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [WORDS-1:0]    ram_sel_q;
    logic                ram_we_q;
    logic                ack_q;
    logic                busy_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   sel_word;

    function automatic logic [WORDS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [WORDS-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    assign sel_word = ram_dout_i[addr_q*DATA_W +: DATA_W];

`ifdef VERIFY_EN
    logic err_q;
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            ram_sel_q <= '0;
            ram_we_q  <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
`ifdef VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            ram_we_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_i) begin
                        addr_q    <= addr_i;
                        rw_q      <= rw_i;
                        wdata_q   <= wdata_i;
                        ram_sel_q <= onehot(addr_i);
                        ram_we_q  <= rw_i;
                        busy_q    <= 1'b1;
                        state_q   <= rw_i ? StWrite : StRead;
                    end
                end
                StWrite: begin
`ifdef VERIFY_EN
                    state_q   <= StVerify;
`else
                    ram_sel_q <= '0;
                    ack_q     <= 1'b1;
                    state_q   <= StDone;
`endif
                end
`ifdef VERIFY_EN
                StVerify: begin
                    err_q   <= (sel_word != wdata_q);
                    state_q <= StCapture;
                end
`endif
                StRead: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    // Also serves as the settle cycle after verify, where rdata must stay put
                    if (!rw_q) begin
                        rdata_q <= sel_word;
                    end
                    ram_sel_q <= '0;
                    ack_q     <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (!req_i) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign busy_o    = busy_q;
    assign rdata_o   = rdata_q;
    assign ram_sel_o = ram_sel_q;
    assign ram_we_o  = ram_we_q;
    assign ram_din_o = wdata_q;
    assign ram_clr_o = clear_i;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: RAM model, transaction-latency reference model and a per-cycle
// compare process, driven by directed and randomized req/ack transactions.
module tb_ram_access_ctrl;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned WORDS  = 4;

    logic                     clk = 1'b0;
    logic                     clear, req, rw;
    logic [ADDR_W-1:0]        addr;
    logic [DATA_W-1:0]        wdata;
    logic                     ack, busy, err, ram_we, ram_clr;
    logic [DATA_W-1:0]        rdata, ram_din;
    logic [WORDS-1:0]         ram_sel;
    logic [DATA_W*WORDS-1:0]  ram_dout;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Fault injection on the RAM read path
    bit                force_en = 0;
    logic [ADDR_W-1:0] force_addr = '0;
    logic [DATA_W-1:0] force_val = '0;

    always #5 clk = ~clk;

    ram_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i      (clk),
        .clear_i    (clear),
        .req_i      (req),
        .rw_i       (rw),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .ack_o      (ack),
        .busy_o     (busy),
        .rdata_o    (rdata),
        .err_o      (err),
        .ram_sel_o  (ram_sel),
        .ram_we_o   (ram_we),
        .ram_din_o  (ram_din),
        .ram_clr_o  (ram_clr),
        .ram_dout_i (ram_dout)
    );

    // RAM bank model
    logic [DATA_W-1:0] mem [WORDS];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (ram_we) begin
            for (int i = 0; i < WORDS; i++) if (ram_sel[i]) mem[i] <= ram_din;
        end
    end
    always_comb begin
        ram_dout = '0;
        for (int i = 0; i < WORDS; i++)
            ram_dout[i*DATA_W +: DATA_W] = (force_en && i == int'(force_addr)) ? force_val : mem[i];
    end

    // Reference model: p = cycles since the request was accepted, -1 when idle
    int                p = -1;
    bit                m_rw = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rdata = '0;
    bit                m_err = 0;
    logic [DATA_W-1:0] shadow [WORDS];

    function automatic int lat(input bit w);
`ifdef VERIFY_EN
        return w ? 4 : 3;
`else
        return w ? 2 : 3;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return (force_en && a == force_addr) ? force_val : shadow[a];
    endfunction

    always @(posedge clk) begin
        if (clear) begin
            p = -1; m_rw = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 0;
            for (int i = 0; i < WORDS; i++) shadow[i] = '0;
        end else if (p < 0) begin
            if (req) begin
                p = 1; m_rw = rw; m_addr = addr; m_wdata = wdata;
            end
        end else if (p >= lat(m_rw)) begin
            if (!req) p = -1;
        end else begin
            if (m_rw && p == 1) shadow[m_addr] = m_wdata;
`ifdef VERIFY_EN
            if (m_rw && p == 2) m_err = (word_of(m_addr) != m_wdata);
`endif
            p++;
            if (!m_rw && p == lat(m_rw)) m_rdata = word_of(m_addr);
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_ack", 32'(ack), 32'(p >= 1 && p >= lat(m_rw)));
            cmp("m_busy", 32'(busy), 32'(p >= 1));
            cmp("m_sel", 32'(ram_sel), (p >= 1 && p < lat(m_rw)) ? (32'd1 << m_addr) : 32'd0);
            cmp("m_we", 32'(ram_we), 32'(m_rw && p == 1));
            cmp("m_din", 32'(ram_din), 32'(m_wdata));
            cmp("m_rdata", 32'(rdata), 32'(m_rdata));
            cmp("m_err", 32'(err), 32'(m_err));
            cmp("m_clr", 32'(ram_clr), 32'(clear));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full handshake; host inputs are scrambled after acceptance to prove they are ignored
    task automatic txn(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       input int hold);
        bit seen;
        seen = 0;
        req = 1'b1; rw = w; addr = a; wdata = d;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            rw = 1'($urandom); addr = ADDR_W'($urandom); wdata = DATA_W'($urandom);
            if (ack) seen = 1;
        end
        cmp("ack_seen", 32'(seen), 32'd1);
        repeat (hold) tick();
        req = 1'b0;
        tick();
        cmp("ack_drop", 32'(ack), 32'd0);
        cmp("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin
        clear = 1'b1; req = 1'b1; rw = 1'b1; addr = 2'd2; wdata = 4'hF;
        tick();
        chk_en = 1;
        tick();
        cmp("rst_ack", 32'(ack), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_sel", 32'(ram_sel), 32'd0);
        cmp("rst_we", 32'(ram_we), 32'd0);
        cmp("rst_rdata", 32'(rdata), 32'd0);
        cmp("rst_clr", 32'(ram_clr), 32'd1);
        clear = 1'b0; req = 1'b0;
        tick();

        // Write addr 2 = 1001, change wdata mid-transaction, hold req 10 cycles past ack
        req = 1'b1; rw = 1'b1; addr = 2'd2; wdata = 4'b1001;
        tick();
        cmp("wr_sel", 32'(ram_sel), 32'b0100);
        cmp("wr_we", 32'(ram_we), 32'd1);
        cmp("wr_din", 32'(ram_din), 32'b1001);
        cmp("wr_ack_early", 32'(ack), 32'd0);
        wdata = 4'b0011;
`ifdef VERIFY_EN
        repeat (3) tick();
`else
        tick();
`endif
        cmp("wr_ack", 32'(ack), 32'd1);
        cmp("wr_we_off", 32'(ram_we), 32'd0);
        repeat (10) tick();
        cmp("hold_ack", 32'(ack), 32'd1);
        cmp("hold_din", 32'(ram_din), 32'b1001);
        req = 1'b0;
        tick();
        cmp("drop_ack", 32'(ack), 32'd0);
        cmp("drop_busy", 32'(busy), 32'd0);

        // Read word 3 = 1011
        txn(1'b1, 2'd3, 4'b1011, 0);
        req = 1'b1; rw = 1'b0; addr = 2'd3;
        tick();
        cmp("rd_sel1", 32'(ram_sel), 32'b1000);
        cmp("rd_we", 32'(ram_we), 32'd0);
        tick();
        cmp("rd_sel2", 32'(ram_sel), 32'b1000);
        cmp("rd_ack_early", 32'(ack), 32'd0);
        tick();
        cmp("rd_ack", 32'(ack), 32'd1);
        cmp("rd_data", 32'(rdata), 32'b1011);
        req = 1'b0;
        tick();
        cmp("rd_hold", 32'(rdata), 32'b1011);

        // Clear during the WRITE cycle
        req = 1'b1; rw = 1'b1; addr = 2'd1; wdata = 4'b0101;
        tick();
        cmp("clr_we_pre", 32'(ram_we), 32'd1);
        clear = 1'b1; req = 1'b0;
        tick();
        cmp("clr_we", 32'(ram_we), 32'd0);
        cmp("clr_busy", 32'(busy), 32'd0);
        clear = 1'b0;
        repeat (3) begin
            tick();
            cmp("clr_no_ack", 32'(ack), 32'd0);
        end
        txn(1'b0, 2'd0, 4'h0, 0);
        cmp("clr_rd0", 32'(rdata), 32'd0);
        txn(1'b0, 2'd1, 4'h0, 0);
        cmp("clr_rd1", 32'(rdata), 32'd0);

`ifdef VERIFY_EN
        force_en = 1; force_addr = 2'd1; force_val = 4'b0000;
        req = 1'b1; rw = 1'b1; addr = 2'd1; wdata = 4'b0110;
        repeat (3) tick();
        cmp("vf_ack_early", 32'(ack), 32'd0);
        tick();
        cmp("vf_ack", 32'(ack), 32'd1);
        cmp("vf_err", 32'(err), 32'd1);
        req = 1'b0;
        tick();
        force_en = 0;
        txn(1'b1, 2'd1, 4'b0110, 0);
        cmp("vf_ok", 32'(err), 32'd0);
`endif

        // Randomized traffic, with an occasional clear in mid-flight
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 14) == 0) begin
                req = 1'b1; rw = 1'($urandom); addr = ADDR_W'($urandom);
                wdata = DATA_W'($urandom);
                repeat ($urandom_range(1, 3)) tick();
                clear = 1'b1; req = 1'b0;
                tick();
                clear = 1'b0;
            end else begin
                force_en = ($urandom_range(0, 5) == 0);
                force_addr = ADDR_W'($urandom);
                force_val = DATA_W'($urandom);
                txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), $urandom_range(0, 3));
                force_en = 0;
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Upstream access controller for the small JK-flip-flop RAM words; sits between a host and a bank of 2**ADDR_W DATA_W-bit RAM words.
- Accepts one read or write request at a time over a four-phase req/ack handshake.
- Latches the request, decodes the address to a one-hot word select and strobes the RAM write enable.
- For reads, captures the selected word; acks completion to the host.

Parameters:
DATA_W, 4, width of one RAM word
ADDR_W, 2, address width; WORDS = 2**ADDR_W words (default 4)

Ports:
clk  in  1  system clock, all state on rising edge
clear  in  1  synchronous active-high reset
req  in  1  host request; held high until ack seen
rw  in  1  1 = write, 0 = read; sampled with req
addr  in  ADDR_W  word address; sampled with req
wdata  in  DATA_W  write data; sampled with req
ack  out  1  transaction complete; high in DONE state
busy  out  1  high in every state except IDLE
rdata  out  DATA_W  last read word; held until next read or clear
err  out  1  write-verify mismatch flag (VERIFY_EN only, else tied 0)
ram_sel  out  WORDS  one-hot word select to RAM, 0 when idle
ram_we  out  1  RAM write strobe
ram_din  out  DATA_W  data to RAM, equals latched wdata
ram_clr  out  1  RAM clear, equals clear (combinational pass-through)
ram_dout  in  DATA_W*WORDS  concatenated RAM word outputs, word i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (clear=1 at edge): state=IDLE; ack, busy, ram_we, err = 0; ram_sel = 0; rdata, ram_din, latched addr/rw = 0.
- clear overrides any state, including mid-transaction; no partial write completes after clear.
- All outputs except ram_clr are registered or decoded from registered state. No combinational path from req/addr/wdata to RAM ports.
- FSM states: IDLE, WRITE, READ, CAPTURE, DONE, plus VERIFY with the optional feature.
- IDLE:
  - if req=1: latch addr, rw, wdata.
  - next state is WRITE if rw=1, else READ.
- WRITE:
  - ram_sel = onehot(addr_l); ram_we = 1 for exactly this one cycle; ram_din = wdata_l.
  - next state DONE, or VERIFY with the optional feature.
- READ:
  - ram_sel = onehot(addr_l); ram_we = 0.
  - next state CAPTURE.
- CAPTURE:
  - ram_sel is held.
  - rdata <= ram_dout word addr_l at end of cycle.
  - next state DONE.
- DONE:
  - ack = 1; ram_sel = 0; ram_we = 0.
  - stays in DONE while req=1; moves to IDLE when req=0.
  - ack drops on the cycle after req is seen low.
- Latency from the edge sampling req to ack high:
  - write: 2 cycles
  - read: 3 cycles
  - write with VERIFY_EN: 4 cycles
- Host inputs changing after latch are ignored until the next IDLE.
- req held high through DONE never starts a second transaction; a new transaction needs req low for at least one cycle.
- ram_sel is never multi-hot; at most one of ram_we / read-capture is active per cycle.
- rdata is unaffected by writes.
- Back-to-back transactions: minimum spacing is ack high → req low → IDLE → next req.

Optional Feature:
Macro VERIFY_EN.
- Defined:
  - After WRITE, go to VERIFY: ram_sel held, ram_we = 0.
  - Compare ram_dout word addr_l with wdata_l. Set err = 1 on mismatch, clear err = 0 on match.
  - Then CAPTURE-style one-cycle settle, then DONE.
  - err holds until the next write completes verify, or until clear.
  - rdata is not updated by verify.
- Undefined: no VERIFY state; err is constant 0; write latency is 2 cycles.

Test Plan:
- Reset: clear=1 for 2 cycles with req=1 → ack=0, busy=0, ram_sel=0000, ram_we=0, rdata=0000, ram_clr=1 while clear high.
- Write: req=1, rw=1, addr=2, wdata=1001 → 1 cycle later ram_sel=0100, ram_we=1 for exactly 1 cycle, ram_din=1001; ack=1 two cycles after sampling.
- Read: model RAM with word 3 = 1011; req=1, rw=0, addr=3 → ram_sel=1000 for 2 cycles, rdata=1011, ack=1 three cycles after sampling; rdata holds 1011 after req drops.
- Handshake hold:
  - keep req=1 for 10 cycles after ack → ack stays 1, no second ram_we pulse;
  - drop req → ack=0 and busy=0 next cycle;
  - change wdata to 0011 mid-transaction → ram_din stays 1001.
- Reset mid-operation: assert clear in the WRITE cycle → state IDLE next edge, ram_we=0, ack never asserts; subsequent read of addr=0 (RAM word 0000) → rdata=0000.
- VERIFY_EN: RAM model forced to return 0000 for word 1; write addr=1, wdata=0110 → err=1 and ack 4 cycles after sampling; a correct write (model returns 0110) → err=0.
